// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - RV32IM EX-stage ALU control decode and MUL/DIV sequencing FSM
module alu_ctrl_sequencer #(
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 33,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [1:0]  ALUOp,
    input  logic [31:0] instruction,
    output logic [3:0]  Control_out,
    output logic        illegal_o,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic        mdu_abort,
    output logic        mdu_wb,
    output logic        stall_o
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;

    // cnt is preloaded with LAT-2 so that DONE lands exactly LAT cycles after the launch
    localparam int MUL_CNT_I = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam int DIV_CNT_I = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] MUL_CNT = MUL_CNT_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DIV_CNT = DIV_CNT_I[CNT_W-1:0];

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op_q, op_nx;
    logic [3:0]       dec_ctrl;
    logic             dec_ill, m_enc, m_op;
    logic             start, abort, wb, stall;
    logic [2:0]       f3;
    logic             b30, b25;
    logic             unused_bits;

    assign f3  = instruction[14:12];
    assign b30 = instruction[30];
    assign b25 = instruction[25];
    assign unused_bits = ^{instruction[31], instruction[29:26], instruction[24:15], instruction[11:0]};

    always_comb begin
        dec_ctrl = C_ADD;
        dec_ill  = 1'b0;
        m_enc    = 1'b0;
        case (ALUOp)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            2'b10: begin
                if (b25) begin
                    if (ENABLE_M != 0 && !b30) m_enc = 1'b1;
                    else                       dec_ill = 1'b1;
                end else begin
                    case ({b30, f3})
                        4'b0000: dec_ctrl = C_ADD;
                        4'b1000: dec_ctrl = C_SUB;
                        4'b0001: dec_ctrl = C_SLL;
                        4'b0010: dec_ctrl = C_SLT;
                        4'b0011: dec_ctrl = C_SLTU;
                        4'b0100: dec_ctrl = C_XOR;
                        4'b0101: dec_ctrl = C_SRL;
                        4'b1101: dec_ctrl = C_SRA;
                        4'b0110: dec_ctrl = C_OR;
                        4'b0111: dec_ctrl = C_AND;
                        default: dec_ill  = 1'b1;
                    endcase
                end
            end
            default: begin
                // I-type: bit 30 is immediate data except for the shift-right selector
                case (f3)
                    3'b000: dec_ctrl = C_ADD;
                    3'b001: if (b30) dec_ill = 1'b1; else dec_ctrl = C_SLL;
                    3'b010: dec_ctrl = C_SLT;
                    3'b011: dec_ctrl = C_SLTU;
                    3'b100: dec_ctrl = C_XOR;
                    3'b101: dec_ctrl = b30 ? C_SRA : C_SRL;
                    3'b110: dec_ctrl = C_OR;
                    default: dec_ctrl = C_AND;
                endcase
            end
        endcase
    end

    assign m_op = valid_i & m_enc;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        start    = 1'b0;
        abort    = 1'b0;
        wb       = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (m_op && !flush_i) begin
                    start = 1'b1;
                    stall = 1'b1;
                    op_nx = f3;
                    if (f3[2] ? (DIV_LAT == 1) : (MUL_LAT == 1)) begin
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = f3[2] ? DIV_CNT : MUL_CNT;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    abort    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt == '0) state_nx = DONE;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // no relaunch here: the M op still on the inputs is the one retiring now
                wb       = !flush_i;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 3'b000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
        end
    end

    // Combinational outputs are forced quiet while reset is asserted
    assign Control_out = reset_n ? dec_ctrl : C_ADD;
    assign illegal_o   = reset_n & valid_i & dec_ill;
    assign mdu_start   = reset_n & start;
    assign mdu_abort   = reset_n & abort;
    assign mdu_wb      = reset_n & wb;
    assign stall_o     = reset_n & stall;
    assign mdu_op      = mdu_start ? f3 : op_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - scoreboard bench for alu_ctrl_sequencer, three parameterisations
module tb_alu_ctrl_sequencer;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
        logic       start;
        logic [2:0] op;
        logic       abort;
        logic       wb;
        logic       stall;
    } exp_t;

    // indexed by {bit30, funct3}; 4'hF marks an illegal R-type encoding
    localparam logic [3:0] RT [16] = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0,
                                       4'd6, 4'hF, 4'hF, 4'hF, 4'hF, 4'd7, 4'hF, 4'hF};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [31:0] instruction = 32'h0;

    logic [3:0] co [3];
    logic [2:0] mo [3];
    logic       il [3], st [3], ab [3], wbk [3], sl [3];

    int en_m [3] = '{1, 0, 1};
    int mlat [3] = '{3, 3, 1};
    int dlat [3] = '{33, 33, 2};

    bit         act [3];
    int         tst [3];
    int         lat [3];
    logic [2:0] lop [3];
    int         now = 0;

    exp_t q0[$], q1[$], q2[$];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_ctrl_sequencer u0 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i), .ALUOp(ALUOp),
        .instruction(instruction), .Control_out(co[0]), .illegal_o(il[0]), .mdu_start(st[0]),
        .mdu_op(mo[0]), .mdu_abort(ab[0]), .mdu_wb(wbk[0]), .stall_o(sl[0]));

    alu_ctrl_sequencer #(.ENABLE_M(0)) u1 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i), .ALUOp(ALUOp),
        .instruction(instruction), .Control_out(co[1]), .illegal_o(il[1]), .mdu_start(st[1]),
        .mdu_op(mo[1]), .mdu_abort(ab[1]), .mdu_wb(wbk[1]), .stall_o(sl[1]));

    alu_ctrl_sequencer #(.MUL_LAT(1), .DIV_LAT(2), .CNT_W(2)) u2 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i), .ALUOp(ALUOp),
        .instruction(instruction), .Control_out(co[2]), .illegal_o(il[2]), .mdu_start(st[2]),
        .mdu_op(mo[2]), .mdu_abort(ab[2]), .mdu_wb(wbk[2]), .stall_o(sl[2]));

    function automatic logic [31:0] mk(input bit b30, input bit b25, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom & 32'hBDFF_8FFF;
        r[30] = b30;
        r[25] = b25;
        r[14:12] = f3;
        return r;
    endfunction

    function automatic void ref_decode(input logic [1:0] a, input logic [31:0] ins, input bit vld,
                                       input int en, output logic [3:0] c, output bit ill, output bit mop);
        logic [3:0] idx;
        c = 4'd2;
        ill = 1'b0;
        mop = 1'b0;
        idx = {ins[30], ins[14:12]};
        case (a)
            2'b01: c = 4'd6;
            2'b10: begin
                if (ins[25]) begin
                    mop = (en != 0) && !ins[30];
                    ill = !mop;
                end else if (RT[idx] == 4'hF) begin
                    ill = 1'b1;
                end else begin
                    c = RT[idx];
                end
            end
            2'b11: begin
                if (ins[14:12] != 3'b101) idx[3] = 1'b0;
                if (ins[14:12] == 3'b001 && ins[30]) ill = 1'b1;
                else c = RT[idx];
            end
            default: ;
        endcase
        ill = ill & vld;
        mop = mop & vld;
    endfunction

    // Transaction-level view: an op launched at cycle t with latency L stalls through t+L-1
    // and writes back at t+L, unless flushed or reset first.
    task automatic model(input int i, input logic rst, input logic v, input logic fl,
                         input logic [1:0] a, input logic [31:0] ins, output exp_t e);
        logic [3:0] c;
        bit ill, mop;
        int ph;
        e = '0;
        e.ctrl = 4'd2;
        if (!rst) begin
            act[i] = 1'b0;
            lop[i] = 3'b000;
            return;
        end
        ref_decode(a, ins, v, en_m[i], c, ill, mop);
        e.ctrl = c;
        e.ill = ill;
        if (act[i]) begin
            ph = now - tst[i];
            if (ph < lat[i]) begin
                if (fl) begin
                    e.abort = 1'b1;
                    act[i] = 1'b0;
                end else begin
                    e.stall = 1'b1;
                end
            end else begin
                e.wb = !fl;
                act[i] = 1'b0;
            end
        end else if (mop && !fl) begin
            e.start = 1'b1;
            e.stall = 1'b1;
            act[i] = 1'b1;
            tst[i] = now;
            lat[i] = ins[14] ? dlat[i] : mlat[i];
            lop[i] = ins[14:12];
        end
        e.op = lop[i];
    endtask

    task automatic step(input logic rst, input logic v, input logic fl,
                        input logic [1:0] a, input logic [31:0] ins);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst;
        valid_i = v;
        flush_i = fl;
        ALUOp = a;
        instruction = ins;
        model(0, rst, v, fl, a, ins, e); q0.push_back(e);
        model(1, rst, v, fl, a, ins, e); q1.push_back(e);
        model(2, rst, v, fl, a, ins, e); q2.push_back(e);
        now++;
    endtask

    task automatic chk(input int i, input exp_t e);
        exp_t got;
        got = {co[i], il[i], st[i], mo[i], ab[i], wbk[i], sl[i]};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL outputs cyc%0d inst%0d got ctrl=%h ill=%b start=%b op=%h abort=%b wb=%b stall=%b exp ctrl=%h ill=%b start=%b op=%h abort=%b wb=%b stall=%b",
                     now, i, got.ctrl, got.ill, got.start, got.op, got.abort, got.wb, got.stall,
                     e.ctrl, e.ill, e.start, e.op, e.abort, e.wb, e.stall);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) chk(0, q0.pop_front());
        if (q1.size() > 0) chk(1, q1.pop_front());
        if (q2.size() > 0) chk(2, q2.pop_front());
    end

    initial begin
        logic [31:0] w;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 2'b10, mk(1'b0, 1'b1, 3'b000));
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 2'b10, mk(k[3], 1'b0, k[2:0]));
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 2'b11, mk(k[3], 1'b0, k[2:0]));
        step(1'b1, 1'b1, 1'b0, 2'b00, mk(1'b1, 1'b0, 3'b111));
        step(1'b1, 1'b1, 1'b0, 2'b01, mk(1'b0, 1'b1, 3'b010));
        step(1'b1, 1'b0, 1'b0, 2'b10, mk(1'b1, 1'b0, 3'b111));
        w = mk(1'b0, 1'b1, 3'b000);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 2'b10, w);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        w = mk(1'b0, 1'b1, 3'b100);
        for (int k = 0; k < 68; k++) step(1'b1, (k % 7) != 3, 1'b0, 2'b10, w);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        w = mk(1'b0, 1'b1, 3'b110);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 2'b10, w);
        step(1'b1, 1'b1, 1'b1, 2'b10, w);
        w = mk(1'b0, 1'b1, 3'b011);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 2'b10, w);
        step(1'b1, 1'b1, 1'b1, 2'b10, w);
        w = mk(1'b0, 1'b1, 3'b101);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 2'b10, w);
        step(1'b0, 1'b1, 1'b0, 2'b10, w);
        step(1'b0, 1'b1, 1'b0, 2'b10, w);
        w = mk(1'b0, 1'b1, 3'b001);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 2'b10, w);
        step(1'b1, 1'b1, 1'b1, 2'b10, mk(1'b0, 1'b1, 3'b000));
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 399) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 23) == 0,
                 2'($urandom_range(0, 3)),
                 mk($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7))));
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        @(posedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
